matrix_reader: RTL and testbench
================================

// Module: matrix_reader
// PURPOSE
// - Loads input operands for the matrix multiplier from a word-serial source stream.
// - Accepts NUM_MAT matrices of N x N 32-bit words, in order: A, then B.
// - Forwards each word with its (mat, i, j) coordinates to the operand store over a stb/ack handshake.
// - Pulses done once the last word has been delivered.
// - Read-side counterpart of the result writer.
// PARAMETERS
// - N          8   matrix dimension; 2..(2**IDX_W)
// - IDX_W      5   width of the i and j index outputs
// - WIDTH      32  data word width (IEEE-754 single)
// - NUM_MAT    2   number of matrices per load (1..2)
// - COL_MAJOR  0   0: row-major stream (j inner); 1: column-major stream (i inner)
// PORTS
// - clk        in   1      rising-edge clock
// - rst        in   1      synchronous, active-high reset
// - start      in   1      begin a load; sampled only in S_IDLE
// - in_data    in   WIDTH  source word
// - in_stb     in   1      source word valid
// - in_ack     out  1      reader ready; transfer occurs when in_stb && in_ack
// - out_value  out  WIDTH  word presented to the operand store
// - out_i      out  IDX_W  row index of out_value
// - out_j      out  IDX_W  column index of out_value
// - out_mat    out  1      0 = matrix A, 1 = matrix B
// - out_stb    out  1      out_* valid
// - out_ack    in   1      store accepted; transfer occurs when out_stb && out_ack
// - busy       out  1      high from S_READ entry until done is asserted
// - done       out  1      high when all NUM_MAT*N*N words have been delivered
// BEHAVIOUR
// - Reset: state S_IDLE; every output (in_ack, out_stb, out_value, out_i, out_j, out_mat, busy, done) = 0.
// - All outputs are registered.
// - S_IDLE:
//   - start=1 -> S_READ.
//   - Same edge: in_ack<=1, busy<=1, done<=0, counters cleared.
// - S_READ:
//   - On in_stb && in_ack: out_value<=in_data, in_ack<=0, out_stb<=1 -> S_WRITE.
//   - in_ack is held high while waiting; no timeout.
// - S_WRITE:
//   - On out_stb && out_ack: out_stb<=0, then advance the counters.
//   - Not last word: -> S_READ with in_ack<=1.
//   - Last word: -> S_DONE.
//   - out_* stay stable while out_stb=1 and out_ack=0.
// - S_DONE:
//   - done<=1, busy<=0 -> S_IDLE.
//   - done stays high until the next accepted start (it is cleared on that edge).
// - Counter order:
//   - COL_MAJOR=0: j is the inner counter (0..N-1), then i, then mat.
//   - COL_MAJOR=1: i and j swap roles.
//   - Inner wrap: N-1 -> 0 with a carry into the outer counter.
//   - Outer wrap with mat<NUM_MAT-1: mat increments; i and j restart at 0.
// - Last word condition: mat==NUM_MAT-1, i==N-1, j==N-1.
// - Throughput: at most 1 word per 2 clocks; in_ack and out_stb are never high together.
// - Latency: in_data is captured at the accepting edge and appears on out_value in the next cycle with out_stb=1.
// - start while busy: ignored, no effect. start in the same cycle as done rising: ignored.
// - in_stb while in_ack=0: ignored; the source must hold its word.
// - rst mid-load: immediate return to the reset state; the partial load is discarded and done stays 0.
// STRUCTURE
// - matrix_pkg holds:
//   - state encodings S_IDLE=2'b00, S_READ=2'b01, S_WRITE=2'b10, S_DONE=2'b11;
//   - WORD_W=32 and DEF_N=8 (shared with the writer and the multiplier).
// - Sub-module matrix_index_counter: (inc, clr) -> i, j, mat, last.
//   - Nested wrap counter honouring COL_MAJOR and NUM_MAT.
//   - Reused by the result writer.
// - Top level: FSM, datapath register, handshake flops.
// TESTING
// - N=8, NUM_MAT=2, in_stb and out_ack tied high, data=0..127:
//   - out_value k at (mat=k/64, i=(k%64)/8, j=k%8);
//   - done after 128 transfers, about 256 clocks.
// - Random out_ack stalls, 0-5 cycles:
//   - out_* stable while stalled;
//   - no in_ack during a stall; no word lost or duplicated.
// - Pulse start at element 10:
//   - ignored; sequence unchanged; exactly 128 words delivered.
// - rst at element 40, then start:
//   - all outputs 0 after reset;
//   - new load begins at (0,0,0); done only after a full 128 words.
// - N=2, NUM_MAT=1, COL_MAJOR=1, data 0xA..0xD:
//   - (i,j) order (0,0),(1,0),(0,1),(1,1).
// - After done:
//   - done held high for 20 idle cycles;
//   - new start clears done on the accepting edge.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier load/store blocks.
package matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEF_N  = 8;

endpackage

// File: rtl/matrix_index_counter.sv
// Nested (mat, outer, inner) wrap counter producing element coordinates for an N x N stream.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned NUM_MAT   = 2,
  parameter int unsigned COL_MAJOR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             mat,
  output logic             last
);

  localparam logic [IDX_W-1:0] IdxMax  = IDX_W'(N - 1);
  localparam logic             MatLast = 1'(NUM_MAT - 1);

  logic [IDX_W-1:0] inner_q, outer_q;
  logic             mat_q;
  logic             inner_wrap, outer_wrap;

  assign inner_wrap = (inner_q == IdxMax);
  assign outer_wrap = (outer_q == IdxMax);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inner_q <= '0;
      outer_q <= '0;
      mat_q   <= 1'b0;
    end else if (inc) begin
      if (!inner_wrap) begin
        inner_q <= inner_q + 1'b1;
      end else begin
        inner_q <= '0;
        if (!outer_wrap) begin
          outer_q <= outer_q + 1'b1;
        end else begin
          outer_q <= '0;
          // Wrapping past the final matrix returns to 0 so the next load starts clean.
          mat_q   <= (mat_q == MatLast) ? 1'b0 : mat_q + 1'b1;
        end
      end
    end
  end

  assign i    = (COL_MAJOR != 0) ? inner_q : outer_q;
  assign j    = (COL_MAJOR != 0) ? outer_q : inner_q;
  assign mat  = mat_q;
  assign last = (mat_q == MatLast) && inner_wrap && outer_wrap;

endmodule

// File: rtl/matrix_reader.sv
// Word-serial operand loader: forwards NUM_MAT*N*N words with (mat, i, j) over stb/ack.
module matrix_reader
  import matrix_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned WIDTH     = WORD_W,
  parameter int unsigned NUM_MAT   = 2,
  parameter int unsigned COL_MAJOR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_i,
  output logic [IDX_W-1:0] out_j,
  output logic             out_mat,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             in_ack_q, in_ack_d;
  logic             out_stb_q, out_stb_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_inc, cnt_clr, cnt_last;

  matrix_index_counter #(
    .N         (N),
    .IDX_W     (IDX_W),
    .NUM_MAT   (NUM_MAT),
    .COL_MAJOR (COL_MAJOR)
  ) u_index (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .i    (out_i),
    .j    (out_j),
    .mat  (out_mat),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
      value_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ack_q  <= in_ack_d;
      out_stb_q <= out_stb_d;
      value_q   <= value_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ack_d  = in_ack_q;
    out_stb_d = out_stb_q;
    value_d   = value_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          in_ack_d = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          cnt_clr  = 1'b1;
        end
      end
      S_READ: begin
        if (in_stb && in_ack_q) begin
          value_d   = in_data;
          in_ack_d  = 1'b0;
          out_stb_d = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // Coordinates advance only after the store accepts, so out_* hold during a stall.
        if (out_stb_q && out_ack) begin
          out_stb_d = 1'b0;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_READ;
            in_ack_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ack    = in_ack_q;
  assign out_stb   = out_stb_q;
  assign out_value = value_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Scoreboard bench for matrix_reader: 8x8x2 row-major instance plus a 2x2x1 column-major one.
module tb_matrix_reader;

  localparam int NW = 128;

  logic        clk = 1'b0;
  logic        rst, start, in_stb, in_ack, out_mat, out_stb, out_ack, busy, done;
  logic [31:0] in_data, out_value;
  logic [4:0]  out_i, out_j;

  logic        b_start, b_in_stb, b_in_ack, b_out_mat, b_out_stb, b_out_ack, b_busy, b_done;
  logic [31:0] b_in_data, b_out_value;
  logic [4:0]  b_out_i, b_out_j;

  typedef struct packed {
    logic        mat;
    logic [4:0]  i;
    logic [4:0]  j;
    logic [31:0] v;
  } word_t;

  word_t sb[$];
  word_t sbb[$];
  word_t held;
  int    n_total = 0;
  int    n_pass  = 0;
  int    k_in, n_out, stall_left;
  bit    in_word, stall_en;

  always #5 clk = ~clk;

  matrix_reader #(
    .N(8), .IDX_W(5), .WIDTH(32), .NUM_MAT(2), .COL_MAJOR(0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_stb(in_stb),
    .in_ack(in_ack), .out_value(out_value), .out_i(out_i), .out_j(out_j),
    .out_mat(out_mat), .out_stb(out_stb), .out_ack(out_ack), .busy(busy), .done(done)
  );

  matrix_reader #(
    .N(2), .IDX_W(5), .WIDTH(32), .NUM_MAT(1), .COL_MAJOR(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_data(b_in_data), .in_stb(b_in_stb),
    .in_ack(b_in_ack), .out_value(b_out_value), .out_i(b_out_i), .out_j(b_out_j),
    .out_mat(b_out_mat), .out_stb(b_out_stb), .out_ack(b_out_ack), .busy(b_busy),
    .done(b_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic word_t exp_a(input int k);
    word_t w;
    w.mat = 1'(k / 64);
    w.i   = 5'((k % 64) / 8);
    w.j   = 5'(k % 8);
    w.v   = 32'(k);
    return w;
  endfunction

  function automatic word_t exp_b(input int k);
    word_t w;
    w.mat = 1'b0;
    w.i   = 5'(k % 2);
    w.j   = 5'(k / 2);
    w.v   = 32'hA + 32'(k);
    return w;
  endfunction

  // Source and sink for dut_a, called at each falling edge.
  task automatic service();
    word_t cur, e;
    check("ack_stb_exclusive", 64'(in_ack & out_stb), 64'd0);
    in_data = 32'(k_in);
    if (in_ack) begin
      sb.push_back(exp_a(k_in));
      k_in++;
    end
    if (out_stb) begin
      cur = {out_mat, out_i, out_j, out_value};
      if (!in_word) begin
        in_word    = 1'b1;
        held       = cur;
        stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
      end else begin
        check("stall_stable", 64'(cur), 64'(held));
      end
      if (stall_left > 0) begin
        out_ack = 1'b0;
        stall_left--;
      end else begin
        out_ack = 1'b1;
        in_word = 1'b0;
        n_out++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("word", 64'(cur), 64'(e));
        end
      end
    end else begin
      out_ack = !stall_en;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    service();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    b_start = 1'b0;
    out_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ack", 64'(in_ack), 64'd0);
    check("rst_out_stb", 64'(out_stb), 64'd0);
    check("rst_out_value", 64'(out_value), 64'd0);
    check("rst_out_i", 64'(out_i), 64'd0);
    check("rst_out_j", 64'(out_j), 64'd0);
    check("rst_out_mat", 64'(out_mat), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_b_outs", 64'({b_in_ack, b_out_stb, b_busy, b_done}), 64'd0);
    rst     = 1'b0;
    sb.delete();
    k_in    = 0;
    n_out   = 0;
    in_word = 1'b0;
  endtask

  task automatic run_load(input bit stalls, input int pulse_at, input int rst_at);
    bit pulsed;
    pulsed   = 1'b0;
    stall_en = stalls;
    k_in     = 0;
    n_out    = 0;
    in_word  = 1'b0;
    sb.delete();
    @(negedge clk);
    start   = 1'b1;
    out_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_cleared", 64'(done), 64'd0);
    check("start_in_ack", 64'(in_ack), 64'd1);
    check("start_coord", 64'({out_mat, out_i, out_j}), 64'd0);
    service();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      tick();
      if (rst_at >= 0 && n_out == rst_at) begin
        do_reset();
        return;
      end
      // Also hold start through the final write and the done-rising edge: must be ignored.
      start = (pulse_at >= 0 && n_out == pulse_at && !pulsed) || (n_out == NW && !done);
      if (pulse_at >= 0 && n_out == pulse_at) pulsed = 1'b1;
    end
    start = 1'b0;
    check("load_done", 64'(done), 64'd1);
    check("words_delivered", 64'(n_out), 64'(NW));
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("done_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    check("late_start_ignored", 64'({in_ack, busy}), 64'd0);
  endtask

  initial begin
    int kb, nb;
    word_t cur, e;
    rst       = 1'b1;
    start     = 1'b0;
    in_stb    = 1'b1;
    in_data   = '0;
    out_ack   = 1'b0;
    b_start   = 1'b0;
    b_in_stb  = 1'b1;
    b_in_data = '0;
    b_out_ack = 1'b1;
    do_reset();

    run_load(1'b0, -1, -1);
    repeat (20) begin
      @(negedge clk);
      check("idle_done_held", 64'(done), 64'd1);
      check("idle_quiet", 64'({busy, in_ack, out_stb}), 64'd0);
    end

    run_load(1'b1, 10, -1);
    run_load(1'b1, -1, 40);
    run_load(1'b0, -1, -1);

    kb = 0;
    nb = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 0; c < 60 && !b_done; c++) begin
      if (b_in_ack) begin
        b_in_data = 32'hA + 32'(kb);
        sbb.push_back(exp_b(kb));
        kb++;
      end
      if (b_out_stb) begin
        cur = {b_out_mat, b_out_i, b_out_j, b_out_value};
        nb++;
        check("b_sb_nonempty", 64'(sbb.size() != 0), 64'd1);
        if (sbb.size() != 0) begin
          e = sbb.pop_front();
          check("b_word", 64'(cur), 64'(e));
        end
      end
      @(negedge clk);
    end
    check("b_done", 64'(b_done), 64'd1);
    check("b_words", 64'(nb), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
